key_schedule_ctrl: RTL and testbench

//  Iterative AES-128 key-schedule sequencer: one shared round-function instance, one round key per clock.

---
 rtl/key_schedule_ctrl_pkg.sv | 46 ++++
 rtl/key_schedule_ctrl_if.sv | 23 ++
 rtl/key_schedule_ctrl_round_fn.sv | 23 ++
 rtl/key_schedule_ctrl.sv | 111 +++++++++++
 tb/tb_key_schedule_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/key_schedule_ctrl_pkg.sv
// Shared AES-128 key-schedule definitions: round count, Rcon seed,
// FSM state type and the byte-level helpers used by the round function.
package key_schedule_ctrl_pkg;

  localparam int unsigned NR_DEFAULT = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1b;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } ks_state_t;

  // Entry 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Start/done handshake plus round-key read port between the key schedule
// and the cipher datapath.
interface key_schedule_ctrl_if #(
  parameter int unsigned AW = 4
);
  logic          start;
  logic [127:0]  key_in;
  logic          busy;
  logic          done;
  logic          keys_valid;
  logic [AW-1:0] rd_addr;
  logic [127:0]  rd_key;

  modport master (
    output start, key_in, rd_addr,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_addr,
    output busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/key_schedule_ctrl_round_fn.sv
// One AES-128 key-expansion step: previous round key + Rcon -> next round key.
// Word w0 occupies bits [127:96].
module key_round_fn
  import key_schedule_ctrl_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);
  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;

  // RotWord is a one-byte left rotate of w3 before the S-box.
  assign w_temp = sub_word({w_w3[23:0], w_w3[31:24]}) ^ {i_rcon, 24'h0};
  assign w_n0   = w_w0 ^ w_temp;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign o_key  = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key schedule: one shared round function produces one
// round key per clock into an (NR+1)-entry register file with a registered
// read port.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT,
  parameter int unsigned AW = 4
)(
  input  logic                     CLK,
  input  logic                     RST,
  key_schedule_ctrl_if.slave       bus
);
  ks_state_t     r_state, w_state_nxt;
  logic [AW-1:0] r_round;
  logic [7:0]    r_rcon;
  logic [127:0]  r_work;
  logic [127:0]  r_rk [0:NR];
  logic          r_done;
  logic          r_valid;
  logic [127:0]  r_rd_key;

  logic [127:0]  w_nxt;
  logic [127:0]  w_rd_key;
  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_round == AW'(NR));

  key_round_fn u_round_fn (
    .i_key  (r_work),
    .i_rcon (r_rcon),
    .o_key  (w_nxt)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on an accepted start, return after the last round.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_EXPAND;
      S_EXPAND: if (w_last)    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Round counter, Rcon, working key and the done/valid status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_round <= '0;
      r_rcon  <= RCON_INIT;
      r_work  <= '0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_work  <= bus.key_in;
        r_round <= AW'(1);
        r_rcon  <= RCON_INIT;
        r_valid <= 1'b0;
      end else if (r_state == S_EXPAND) begin
        r_work  <= w_nxt;
        r_round <= r_round + 1'b1;
        r_rcon  <= xtime(r_rcon);
        if (w_last) begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
        end
      end
    end
  end

  // Register file write: cipher key into slot 0, then one round key per cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_accept) begin
        r_rk[0] <= bus.key_in;
      end else if (r_state == S_EXPAND) begin
        for (int unsigned i = 1; i <= NR; i++) begin
          if (r_round == AW'(i)) r_rk[i] <= w_nxt;
        end
      end
    end
  end

  // Read mux: out-of-range addresses return zero.
  always_comb begin
    w_rd_key = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (bus.rd_addr == AW'(i)) w_rd_key = r_rk[i];
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge CLK) begin
    if (RST) r_rd_key <= '0;
    else     r_rd_key <= w_rd_key;
  end

  assign bus.busy       = (r_state == S_EXPAND);
  assign bus.done       = r_done;
  assign bus.keys_valid = r_valid;
  assign bus.rd_key     = r_rd_key;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for the iterative AES-128 key schedule.
module tb_key_schedule_ctrl;
  localparam int unsigned AW = 4;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY2_RK10= 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [127:0] fips_rk [0:10];

  key_schedule_ctrl_if #(.AW(AW)) ks ();

  key_schedule_ctrl #(.NR(10), .AW(AW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (ks)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for exactly one edge; returns 1 time unit after the accept edge.
  task automatic pulse_start(input logic [127:0] k);
    ks.key_in = k;
    ks.start  = 1'b1;
    tick();
    ks.start  = 1'b0;
  endtask

  // Bounded wait for done; n = edges after the accept edge.
  task automatic wait_done(output int n);
    n = 0;
    while (ks.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic read_rk(input logic [AW-1:0] a, output logic [127:0] v);
    ks.rd_addr = a;
    tick();
    v = ks.rd_key;
  endtask

  task automatic test_reset();
    rst = 1'b1; ks.start = 1'b0; ks.key_in = '0; ks.rd_addr = '0;
    tick(); tick();
    n_cmp++; if (ks.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", ks.busy); end
    n_cmp++; if (ks.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", ks.done); end
    n_cmp++; if (ks.keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ks.keys_valid); end
    n_cmp++; if (ks.rd_key !== 128'h0) begin n_err++; $display("FAIL reset_rdkey got=%h exp=0", ks.rd_key); end
    rst = 1'b0;
  endtask

  task automatic test_fips();
    int n; logic [127:0] v;
    pulse_start(FIPS_KEY);
    n_cmp++; if (ks.busy !== 1'b1) begin n_err++; $display("FAIL fips_busy_after_accept got=%b exp=1", ks.busy); end
    wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL fips_latency got=%0d exp=10", n); end
    n_cmp++; if (ks.keys_valid !== 1'b1 || ks.busy !== 1'b0) begin n_err++; $display("FAIL fips_done_status valid=%b busy=%b exp valid=1 busy=0", ks.keys_valid, ks.busy); end
    tick();
    n_cmp++; if (ks.done !== 1'b0) begin n_err++; $display("FAIL fips_done_pulse got=%b exp=0", ks.done); end
    read_rk(4'd1, v);
    n_cmp++; if (v !== fips_rk[1]) begin n_err++; $display("FAIL fips_rk1 got=%h exp=%h", v, fips_rk[1]); end
    read_rk(4'd10, v);
    n_cmp++; if (v !== fips_rk[10]) begin n_err++; $display("FAIL fips_rk10 got=%h exp=%h", v, fips_rk[10]); end
  endtask

  task automatic test_key2();
    int n; logic [127:0] v;
    pulse_start(KEY2);
    wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL key2_latency got=%0d exp=10", n); end
    read_rk(4'd0, v);
    n_cmp++; if (v !== KEY2) begin n_err++; $display("FAIL key2_rk0 got=%h exp=%h", v, KEY2); end
    read_rk(4'd1, v);
    n_cmp++; if (v !== KEY2_RK1) begin n_err++; $display("FAIL key2_rk1 got=%h exp=%h", v, KEY2_RK1); end
    read_rk(4'd10, v);
    n_cmp++; if (v !== KEY2_RK10) begin n_err++; $display("FAIL key2_rk10 got=%h exp=%h", v, KEY2_RK10); end
  endtask

  task automatic test_start_held();
    int n; logic [127:0] v;
    ks.key_in = FIPS_KEY;
    ks.start  = 1'b1;
    tick();                                   // E0
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_cmp++; if (ks.busy !== 1'b1 || ks.done !== 1'b0) begin n_err++; $display("FAIL held_mid_E%0d busy=%b done=%b exp busy=1 done=0", e, ks.busy, ks.done); end
    end
    tick();                                   // E10
    n_cmp++; if (ks.done !== 1'b1 || ks.busy !== 1'b0 || ks.keys_valid !== 1'b1) begin n_err++; $display("FAIL held_E10 done=%b busy=%b valid=%b exp 1/0/1", ks.done, ks.busy, ks.keys_valid); end
    ks.key_in = KEY2;
    tick();                                   // E11: second accept
    n_cmp++; if (ks.done !== 1'b0 || ks.busy !== 1'b1 || ks.keys_valid !== 1'b0) begin n_err++; $display("FAIL held_E11 done=%b busy=%b valid=%b exp 0/1/0", ks.done, ks.busy, ks.keys_valid); end
    tick(); tick(); tick();                   // E12..E14 with start still high
    ks.start = 1'b0;
    wait_done(n);
    n_cmp++; if (n != 7) begin n_err++; $display("FAIL held_second_latency got=%0d exp=7", n); end
    read_rk(4'd10, v);
    n_cmp++; if (v !== KEY2_RK10) begin n_err++; $display("FAIL held_second_rk10 got=%h exp=%h", v, KEY2_RK10); end
  endtask

  task automatic test_reset_mid();
    int n; int pulses; logic [127:0] v;
    pulse_start(FIPS_KEY);
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();                                   // E5 with reset
    n_cmp++; if (ks.busy !== 1'b0 || ks.done !== 1'b0 || ks.keys_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_status busy=%b done=%b valid=%b exp 0/0/0", ks.busy, ks.done, ks.keys_valid); end
    n_cmp++; if (ks.rd_key !== 128'h0) begin n_err++; $display("FAIL rstmid_rdkey got=%h exp=0", ks.rd_key); end
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (ks.done === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0 || ks.keys_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done pulses=%0d valid=%b exp 0/0", pulses, ks.keys_valid); end
    pulse_start(KEY2);
    wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL rstmid_restart_latency got=%0d exp=10", n); end
    read_rk(4'd1, v);
    n_cmp++; if (v !== KEY2_RK1) begin n_err++; $display("FAIL rstmid_rk1 got=%h exp=%h", v, KEY2_RK1); end
  endtask

  task automatic test_sweep();
    int n; logic [127:0] exp_v, prev_v;
    pulse_start(FIPS_KEY);
    wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL sweep_latency got=%0d exp=10", n); end
    prev_v = '0;
    for (int a = 0; a < 16; a++) begin
      exp_v = (a <= 10) ? fips_rk[a] : 128'h0;
      ks.rd_addr = AW'(a);
      #1;
      if (a > 0) begin
        n_cmp++; if (ks.rd_key !== prev_v) begin n_err++; $display("FAIL sweep_latency_a%0d got=%h exp=%h", a, ks.rd_key, prev_v); end
      end
      tick();
      n_cmp++; if (ks.rd_key !== exp_v) begin n_err++; $display("FAIL sweep_a%0d got=%h exp=%h", a, ks.rd_key, exp_v); end
      prev_v = exp_v;
    end
  endtask

  task automatic test_second_key();
    int n; logic [127:0] v;
    n_cmp++; if (ks.keys_valid !== 1'b1) begin n_err++; $display("FAIL second_pre_valid got=%b exp=1", ks.keys_valid); end
    pulse_start(KEY2);
    n = 1;
    n_cmp++; if (ks.keys_valid !== 1'b0) begin n_err++; $display("FAIL second_valid_drop got=%b exp=0", ks.keys_valid); end
    while (n < 30) begin
      tick();
      if (ks.keys_valid === 1'b1) break;
      n++;
    end
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL second_valid_low_cycles got=%0d exp=10", n); end
    read_rk(4'd10, v);
    n_cmp++; if (v !== KEY2_RK10) begin n_err++; $display("FAIL second_rk10 got=%h exp=%h", v, KEY2_RK10); end
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips();
    test_key2();
    test_start_held();
    test_reset_mid();
    test_sweep();
    test_second_key();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
